// File: rtl/tex_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tex_arb_pkg
//  Description : Shared state encoding and constants for the texture L2 port
//                arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package tex_arb_pkg;

    localparam int c_NUM_REQ_DEFAULT = 4;
    localparam int c_ADDR_W          = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker; returns the first set
//                request at or after the start pointer, wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] w_pos;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        w_pos    = '0;
        for (int off = 0; off < N; off++) begin
            w_pos = IDX_W'((int'(start_i) + off) % N);
            if (!any_o && req_i[w_pos]) begin
                any_o           = 1'b1;
                idx_o           = w_pos;
                onehot_o[w_pos] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tex_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tex_l2_port_arbiter
//  Description : Round-robin arbiter sharing one L2 read port between texture
//                requesters, one transaction in flight at a time.
//                Optional L2 wait timeout: define TEX_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tex_l2_port_arbiter
    import tex_arb_pkg::*;
#(
    parameter int NUM_REQ        = c_NUM_REQ_DEFAULT,
    parameter int DATA_W         = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              enable_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ-1:0][c_ADDR_W-1:0]  req_addr_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic [NUM_REQ-1:0]                resp_valid_o,
    output logic [DATA_W-1:0]                 resp_data_o,
    output logic                              resp_err_o,
    output logic [c_ADDR_W-1:0]               cache_addr_o,
    output logic                              cache_read_o,
    input  logic [DATA_W-1:0]                 cache_rdata_i,
    input  logic                              cache_ready_i,
    output logic                              busy_o,
    output logic [31:0]                       grant_count_o,
    output logic [15:0]                       timeout_count_o
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic [c_IDX_W-1:0]  r_owner;
    logic [c_ADDR_W-1:0] r_addr;
    logic [31:0]         r_grant_cnt;
    logic [DATA_W-1:0]   r_resp_data;

    logic [NUM_REQ-1:0]  w_win_onehot;
    logic [c_IDX_W-1:0]  w_win_idx;
    logic                w_win_any;
    logic                w_grant;
    logic                w_accept;
    logic                w_timeout;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (c_IDX_W)
    ) u_rr_pick (
        .req_i    (req_valid_i),
        .start_i  (r_rr_ptr),
        .onehot_o (w_win_onehot),
        .idx_o    (w_win_idx),
        .any_o    (w_win_any)
    );

    assign w_grant  = (r_state == ST_IDLE) && enable_i && w_win_any;
    assign w_accept = (r_state == ST_ISSUE) && cache_ready_i;

`ifdef TEX_ARB_TIMEOUT_EN
    localparam int c_WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [15:0]         r_timeout_cnt;
    logic                r_resp_err;

    // Fires on the wait cycle that brings the count to TIMEOUT_CYCLES; a
    // same-cycle ready wins because w_accept is checked first everywhere.
    assign w_timeout = (r_state == ST_ISSUE) && !cache_ready_i &&
                       (r_wait_cnt == c_WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wait_cnt    <= '0;
            r_timeout_cnt <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_wait_cnt <= '0;
            end else if ((r_state == ST_ISSUE) && !cache_ready_i && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
            end
            if (w_timeout) begin
                r_resp_err <= 1'b1;
                if (r_timeout_cnt != 16'hFFFF) begin
                    r_timeout_cnt <= r_timeout_cnt + 16'd1;
                end
            end else if (r_state == ST_RESP) begin
                r_resp_err <= 1'b0;
            end
        end
    end

    assign resp_err_o      = r_resp_err;
    assign timeout_count_o = r_timeout_cnt;
`else
    assign w_timeout       = 1'b0;
    assign resp_err_o      = 1'b0;
    assign timeout_count_o = '0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant) w_next_state = ST_ISSUE;
            ST_ISSUE: if (w_accept || w_timeout) w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = w_grant ? w_win_onehot : '0;
        cache_read_o = (r_state == ST_ISSUE);
        cache_addr_o = (r_state == ST_ISSUE) ? r_addr : '0;
        resp_valid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid_o[i] = (r_state == ST_RESP) && (r_owner == c_IDX_W'(i));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_addr      <= '0;
            r_grant_cnt <= '0;
            r_resp_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant) begin
                r_addr      <= req_addr_i[w_win_idx];
                r_owner     <= w_win_idx;
                r_rr_ptr    <= (w_win_idx == c_IDX_W'(NUM_REQ - 1)) ? '0
                                                                    : w_win_idx + c_IDX_W'(1);
                r_grant_cnt <= r_grant_cnt + 32'd1;
            end
            if (w_accept) begin
                r_resp_data <= cache_rdata_i;
            end else if (w_timeout) begin
                r_resp_data <= '0;
            end
        end
    end

    assign resp_data_o   = r_resp_data;
    assign grant_count_o = r_grant_cnt;
    assign busy_o        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
